store_write_buffer: RTL and testbench
=====================================

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of buffered store entries, power of two, 2..16.
REQ-002 Parameter DONE_ADDR, default 32'd96: sentinel store address that signals program completion.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock shared with the pipelined core.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 MemWrite  input  1  core store strobe for the current cycle.
REQ-007 DataAdr  input  32  core store byte address.
REQ-008 WriteData  input  32  core store data.
REQ-009 Stall  output  1  buffer full; the core holds its store.
REQ-010 mem_valid  output  1  head entry is presented to data memory.
REQ-011 mem_addr  output  32  head entry address.
REQ-012 mem_wdata  output  32  head entry data.
REQ-013 mem_ready  input  1  data memory accepts the head entry this cycle.
REQ-014 ld_addr  input  32  core load address for forwarding lookup.
REQ-015 fwd_hit  output  1  a buffered store matches ld_addr.
REQ-016 fwd_data  output  32  data of the youngest matching entry.
REQ-017 done  output  1  one-cycle pulse when the DONE_ADDR store is accepted by memory.
REQ-018 overflow  output  1  sticky flag: a store arrived while the buffer was full.

Function
REQ-019 Push: MemWrite=1 and Stall=0 writes {DataAdr, WriteData} at the tail on the rising edge.
REQ-020 Pop: mem_valid=1 and mem_ready=1 retires the head entry on the rising edge.
REQ-021 mem_valid = (count != 0), driven from registered state only, with no combinational path from mem_ready.
REQ-022 Latency: a push into an empty buffer raises mem_valid on the next cycle.
REQ-023 mem_addr and mem_wdata hold stable while mem_valid=1 and mem_ready=0.
REQ-024 Stall = (count == DEPTH), from registered state only.
REQ-025 A push while full is discarded, overflow sets, and entries and count are unchanged, even if a pop occurs in the same cycle.
REQ-026 Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged and keeps FIFO order.
REQ-027 A pop when empty is ignored.
REQ-028 Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; count is log2(DEPTH)+1 bits wide.
REQ-029 Forwarding compares ld_addr[31:2] with the address of every valid entry, combinationally.
REQ-030 fwd_data comes from the youngest matching entry; fwd_hit=0 drives fwd_data=0.
REQ-031 A store being pushed in the same cycle is not visible to forwarding.
REQ-032 The entry retiring in the current cycle remains visible to forwarding.
REQ-033 done pulses high for exactly one cycle, the cycle after a pop whose address equals DONE_ADDR.

Reset
REQ-034 Reset assertion immediately clears pointers, count, overflow and done, and invalidates all entries.
REQ-035 While reset is asserted, outputs are: Stall=0, mem_valid=0, fwd_hit=0, fwd_data=0, done=0, overflow=0.
REQ-036 Reset mid-drain discards all pending stores; no memory transfer completes after reset asserts.
REQ-037 Entry data storage is not reset.

Structure
REQ-038 The shared package holds SB_DEPTH, SB_DONE_ADDR and the typedef sb_entry_t {addr[31:0], data[31:0]}.
REQ-039 Forwarding lookup is sub-module sb_fwd_match: inputs are entry array, valid mask, head pointer and ld_addr; outputs are hit and data; it is purely combinational.
REQ-040 The FIFO storage, pointers and done logic stay in store_write_buffer.

Verification
REQ-041 Reset, then one store 0x60/0x7 with mem_ready=1 -> mem_valid high one cycle later with mem_addr=0x60; done pulses one cycle after acceptance.
REQ-042 Four stores with mem_ready=0 -> Stall=1 after the fourth; a fifth store sets overflow and the head still shows the first store.
REQ-043 Stores 0x10/0xA then 0x10/0xB, ld_addr=0x12 -> fwd_hit=1, fwd_data=0xB; ld_addr=0x14 -> fwd_hit=0.
REQ-044 Continuous push and pop at count=2 for 10 cycles -> count stays 2 and mem_addr follows push order across pointer wrap.
REQ-045 Assert reset with 3 entries pending and mem_ready toggling -> mem_valid drops immediately; no done pulse and no transfer after release.

Source files
------------

// File: rtl/store_write_buffer_pkg.sv
// Shared types and defaults for the core-side store write buffer.
package store_write_buffer_pkg;

    localparam int          SB_DEPTH     = 4;
    localparam logic [31:0] SB_DONE_ADDR = 32'd96;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_entry_t;

    // Loads forward from stores to the same 32-bit word; byte offset is ignored.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return (a[31:2] == b[31:2]);
    endfunction

endpackage

// File: rtl/store_write_buffer_fwd_match.sv
// Combinational store-to-load forwarding lookup over the buffered entries.
module sb_fwd_match
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(SB_DEPTH)
) (
    input  sb_entry_t        entries [DEPTH],
    input  logic [DEPTH-1:0] valid,
    input  logic [PTR_W-1:0] head,
    input  logic [31:0]      ld_addr,
    output logic             hit,
    output logic [31:0]      data
);

    logic [PTR_W-1:0] idx_s;
    logic             match_s;

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        hit     = 1'b0;
        data    = 32'd0;
        idx_s   = head;
        match_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s   = head + PTR_W'(k);
            match_s = valid[idx_s] && word_match(entries[idx_s].addr, ld_addr);
            hit     = hit | match_s;
            data    = match_s ? entries[idx_s].data : data;
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer between the pipelined core and data memory, with
// valid/ready drain, word-granular load forwarding and a completion pulse.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int          DEPTH     = SB_DEPTH,
    parameter logic [31:0] DONE_ADDR = SB_DONE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] ld_addr,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,
    output logic        done,
    output logic        overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        entries_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic [DEPTH-1:0] valid_r;
    logic             overflow_r;
    logic             done_r;

    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] count_next_s;
    logic [DEPTH-1:0] valid_next_s;

    // Handshake outputs depend only on registered occupancy, never on mem_ready.
    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign Stall     = full_s;
    assign mem_valid = (count_r != CNT_W'(0));
    assign mem_addr  = entries_r[head_r].addr;
    assign mem_wdata = entries_r[head_r].data;
    assign done      = done_r;
    assign overflow  = overflow_r;

    // A full buffer drops the incoming store even when the head retires this cycle.
    assign push_s = MemWrite && !full_s;
    assign pop_s  = mem_valid && mem_ready;

    // Occupancy and per-entry valid bits for the next cycle.
    always_comb begin
        count_next_s = count_r;
        valid_next_s = valid_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
        for (int i = 0; i < DEPTH; i++) begin
            valid_next_s[i] = (valid_r[i] & ~(pop_s & (head_r == PTR_W'(i))))
                            | (push_s & (tail_r == PTR_W'(i)));
        end
    end

    // Pointer, occupancy and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            valid_r    <= '0;
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            head_r     <= pop_s  ? head_r + PTR_W'(1) : head_r;
            tail_r     <= push_s ? tail_r + PTR_W'(1) : tail_r;
            count_r    <= count_next_s;
            valid_r    <= valid_next_s;
            overflow_r <= overflow_r | (MemWrite & full_s);
            done_r     <= pop_s && (entries_r[head_r].addr == DONE_ADDR);
        end
    end

    // Entry payload storage; left unreset since valid_r qualifies every use.
    always_ff @(posedge clk) begin
        if (push_s) begin
            entries_r[tail_r] <= '{addr: DataAdr, data: WriteData};
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd (
        .entries (entries_r),
        .valid   (valid_r),
        .head    (head_r),
        .ld_addr (ld_addr),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer with a queue scoreboard of accepted stores.
module tb_store_write_buffer;
    import store_write_buffer_pkg::*;

    localparam int MDEPTH = 4;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        Stall;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] ld_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        done;
    logic        overflow;

    store_write_buffer #(.DEPTH(4), .DONE_ADDR(32'd96)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .Stall     (Stall),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .ld_addr   (ld_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .done      (done),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sb_entry_t sb_q [$];
    logic      ovf_m;
    logic      done_m;
    int        errors;
    int        checks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic        hit_e;
        logic [31:0] data_e;
        hit_e  = 1'b0;
        data_e = 32'd0;
        foreach (sb_q[i]) begin
            if (sb_q[i].addr[31:2] == ld_addr[31:2]) begin
                hit_e  = 1'b1;
                data_e = sb_q[i].data;
            end
        end
        chk("stall", Stall, 32'(sb_q.size() == MDEPTH));
        chk("mem_valid", mem_valid, 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            chk("mem_addr", mem_addr, sb_q[0].addr);
            chk("mem_wdata", mem_wdata, sb_q[0].data);
        end
        chk("fwd_hit", fwd_hit, hit_e);
        chk("fwd_data", fwd_data, data_e);
        chk("done", done, done_m);
        chk("overflow", overflow, ovf_m);
    endtask

    task automatic update_model();
        logic full_m;
        full_m = (sb_q.size() == MDEPTH);
        done_m = 1'b0;
        if (!reset) begin
            sb_q.delete();
            ovf_m = 1'b0;
        end else begin
            if (mem_ready && sb_q.size() != 0) begin
                done_m = (sb_q[0].addr == 32'd96);
                void'(sb_q.pop_front());
            end
            if (MemWrite && !full_m) sb_q.push_back('{addr: DataAdr, data: WriteData});
            if (MemWrite && full_m) ovf_m = 1'b1;
        end
    endtask

    // One cycle: compare at the falling edge, advance the model on the rising edge.
    task automatic tick();
        @(negedge clk);
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic reset_now();
        reset = 1'b0;
        sb_q.delete();
        ovf_m  = 1'b0;
        done_m = 1'b0;
        #1;
        chk("rst_mem_valid", mem_valid, 32'd0);
        chk("rst_stall", Stall, 32'd0);
        chk("rst_fwd_hit", fwd_hit, 32'd0);
        chk("rst_fwd_data", fwd_data, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_overflow", overflow, 32'd0);
    endtask

    initial begin
        errors = 0; checks = 0;
        ovf_m = 1'b0; done_m = 1'b0;
        MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;
        mem_ready = 1'b0; ld_addr = 32'd0;

        // Power-on reset.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("por_mem_valid", mem_valid, 32'd0);
        chk("por_stall", Stall, 32'd0);
        chk("por_done", done, 32'd0);
        chk("por_overflow", overflow, 32'd0);
        chk("por_fwd_hit", fwd_hit, 32'd0);
        reset = 1'b1;
        tick();

        // Single store to the completion address with memory ready.
        mem_ready = 1'b1;
        store(32'h60, 32'h7);
        chk("t1_valid_latency", mem_valid, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h60);
        chk("t1_mem_wdata", mem_wdata, 32'h7);
        tick();
        chk("t1_done_pulse", done, 32'd1);
        chk("t1_empty", mem_valid, 32'd0);
        tick();
        chk("t1_done_once", done, 32'd0);

        // Fill with memory stalled, then overflow.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), 32'(i + 1));
        chk("t2_stall_full", Stall, 32'd1);
        store(32'h200, 32'h55);
        chk("t2_overflow", overflow, 32'd1);
        chk("t2_head_addr", mem_addr, 32'h100);
        chk("t2_head_data", mem_wdata, 32'h1);
        mem_ready = 1'b1;
        repeat (5) tick();
        chk("t2_drained", mem_valid, 32'd0);

        // Forwarding: youngest match, word granularity, same-cycle push invisible.
        mem_ready = 1'b0;
        store(32'h10, 32'hA);
        store(32'h10, 32'hB);
        ld_addr = 32'h12;
        #1;
        chk("t3_hit_12", fwd_hit, 32'd1);
        chk("t3_data_12", fwd_data, 32'hB);
        ld_addr = 32'h14;
        #1;
        chk("t3_miss_14", fwd_hit, 32'd0);
        chk("t3_miss_data", fwd_data, 32'd0);
        MemWrite = 1'b1; DataAdr = 32'h14; WriteData = 32'hC;
        #1;
        chk("t3_push_invisible", fwd_hit, 32'd0);
        tick();
        MemWrite = 1'b0;
        chk("t3_hit_after_push", fwd_hit, 32'd1);
        chk("t3_data_after_push", fwd_data, 32'hC);
        ld_addr = 32'h10;
        mem_ready = 1'b1;
        #1;
        chk("t3_retiring_visible", fwd_data, 32'hB);
        repeat (4) tick();
        ld_addr = 32'd0;

        // Steady push/pop at two entries across pointer wrap.
        mem_ready = 1'b0;
        store(32'h300, 32'h2000);
        store(32'h304, 32'h2001);
        mem_ready = 1'b1;
        MemWrite  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            DataAdr   = 32'h308 + 32'(4 * i);
            WriteData = 32'h3000 + 32'(i);
            tick();
        end
        MemWrite = 1'b0;
        chk("t4_head_after", mem_addr, 32'h328);
        chk("t4_not_full", Stall, 32'd0);
        tick();
        tick();
        chk("t4_two_left", mem_valid, 32'd0);

        // Reset mid-drain with the completion store still queued.
        mem_ready = 1'b0;
        store(32'h400, 32'h1);
        store(32'h404, 32'h2);
        store(32'h60, 32'h3);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        mem_ready = 1'b1;
        #2;
        reset_now();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_ready = ~mem_ready;
            tick();
            chk("t5_no_done", done, 32'd0);
            chk("t5_no_valid", mem_valid, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
